// File: rtl/adder_tree_acc_if.sv
// -----------------------------------------------------------------------------
// adder_tree_acc_if
// Bundles the control, PE-array and result-handshake signals of
// adder_tree_acc so that the block and its producer/consumer can be
// connected with one port.
//
// Signals:
//   start_in      1            pulse: clear accumulator, load len/bias
//   len_in        8            tree sums per result (0 behaves as 1)
//   bias_in       DATA_WIDTH   signed bias added once per result
//   PE_valid_in   NUM_PE       per-lane valid from the PE array
//   PE_data_in    NUM_PE*DW    packed signed lanes, lane 0 in the LSBs
//   out_ready_in  1            consumer accepts out_data this cycle
//   out_data      DATA_WIDTH   saturated signed result
//   out_valid     1            result available, held until accepted
//   busy_out      1            block is not idle
//   err_out       1            sticky lane-mismatch / late-input flag
//
// Modports:
//   master  drives the inputs and consumes the result (PE array + sink)
//   slave   the accumulator block itself
// -----------------------------------------------------------------------------
interface adder_tree_acc_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_PE     = 5
);
  logic                         start_in;
  logic [7:0]                   len_in;
  logic [DATA_WIDTH-1:0]        bias_in;
  logic [NUM_PE-1:0]            PE_valid_in;
  logic [NUM_PE*DATA_WIDTH-1:0] PE_data_in;
  logic                         out_ready_in;
  logic [DATA_WIDTH-1:0]        out_data;
  logic                         out_valid;
  logic                         busy_out;
  logic                         err_out;

  modport master (
    output start_in,
    output len_in,
    output bias_in,
    output PE_valid_in,
    output PE_data_in,
    output out_ready_in,
    input  out_data,
    input  out_valid,
    input  busy_out,
    input  err_out
  );

  modport slave (
    input  start_in,
    input  len_in,
    input  bias_in,
    input  PE_valid_in,
    input  PE_data_in,
    input  out_ready_in,
    output out_data,
    output out_valid,
    output busy_out,
    output err_out
  );
endinterface

// File: rtl/adder_tree_acc.sv
// -----------------------------------------------------------------------------
// adder_tree_acc
// Sums NUM_PE signed PE lanes per cycle through a registered binary adder
// tree, accumulates len tree sums, adds a bias once, saturates the result
// to DATA_WIDTH and presents it on a valid/ready output.
//
// Parameters:
//   DATA_WIDTH  signed width of each PE lane and of out_data   (default 16)
//   NUM_PE      number of PE lanes, legal range 2..8          (default 5)
//   ACC_WIDTH   signed width of tree sums and accumulator     (default 32)
//
// Ports:
//   clk    sole clock, rising edge
//   rst_n  synchronous reset, ACTIVE HIGH despite the name
//   bus    adder_tree_acc_if.slave (start/len/bias, PE lanes, result)
//
// Optional feature:
//   ADDER_TREE_ACC_RELU_EN  when defined, a negative saturated result is
//                           replaced by 0. Latency and state sequence are
//                           identical with or without it.
//
// Timing: a group accepted in cycle N reaches the accumulator in cycle
// N + ceil(log2(NUM_PE)); the result is visible two cycles after the last
// sum is accumulated (one BIAS cycle, then OUT).
// -----------------------------------------------------------------------------
module adder_tree_acc #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_PE     = 5,
  parameter int ACC_WIDTH  = 32
) (
  input logic             clk,
  input logic             rst_n,
  adder_tree_acc_if.slave bus
);

  // Tree depth and the lane count rounded up to a power of two; the padding
  // lanes are constant zero, which gives an odd lane a registered
  // pass-through so every path has the same depth.
  localparam int LEVELS   = (NUM_PE < 2) ? 1 : $clog2(NUM_PE);
  localparam int LANES_P2 = 1 << LEVELS;

  // Saturation bounds expressed at the widened biased-sum width.
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    BIAS  = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [LANES_P2-1:0][ACC_WIDTH-1:0] lanes_ext;
  logic [ACC_WIDTH-1:0]               tree_out;
  logic                               tree_out_vld;

  logic [ACC_WIDTH-1:0]  acc_q;
  logic [7:0]            cnt_q;
  logic [7:0]            len_q;
  logic [DATA_WIDTH-1:0] bias_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  err_q;

  logic all_valid;
  logic any_valid;
  logic group_accept;
  logic group_mixed;
  logic group_late;
  logic load;
  logic last_sum;

  logic signed [ACC_WIDTH:0]  biased_sum;
  logic        [DATA_WIDTH-1:0] sat_val;
  logic        [DATA_WIDTH-1:0] result_val;

  logic out_valid_c;
  logic busy_c;

  // ---------------------------------------------------------------------------
  // Input qualification
  // ---------------------------------------------------------------------------
  assign all_valid    = &bus.PE_valid_in;
  assign any_valid    = |bus.PE_valid_in;
  assign group_accept = (state_q == ACCUM) && all_valid;
  assign group_mixed  = any_valid && !all_valid;
  assign group_late   = ((state_q == BIAS) || (state_q == OUT)) && all_valid;

  // A start is honoured from IDLE, or from OUT when the result is consumed
  // in the same cycle (back-to-back operation).
  assign load = bus.start_in &&
                ((state_q == IDLE) || ((state_q == OUT) && bus.out_ready_in));

  // The final tree sum of a batch: counter has seen len-1 sums already.
  assign last_sum = (state_q == ACCUM) && tree_out_vld &&
                    (cnt_q == (len_q - 8'd1));

  // Sign-extend each real lane to accumulator width; padding lanes stay 0.
  always_comb begin
    lanes_ext = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      lanes_ext[i] = ACC_WIDTH'($signed(bus.PE_data_in[i*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  // ---------------------------------------------------------------------------
  // Registered adder tree. Each level halves the node count and carries its
  // own valid bit, so one group per cycle flows through. A start clears the
  // valid bits, discarding any sums still in flight from an earlier batch.
  // ---------------------------------------------------------------------------
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NODES = LANES_P2 >> (l + 1);

    logic [2*NODES-1:0][ACC_WIDTH-1:0] src;
    logic                              src_vld;
    logic [NODES-1:0][ACC_WIDTH-1:0]   sum_q;
    logic                              vld_q;

    if (l == 0) begin : g_src
      assign src     = lanes_ext;
      assign src_vld = group_accept;
    end else begin : g_src
      assign src     = g_lvl[l-1].sum_q;
      assign src_vld = g_lvl[l-1].vld_q;
    end

    always_ff @(posedge clk) begin
      if (rst_n) begin
        sum_q <= '0;
        vld_q <= 1'b0;
      end else begin
        for (int i = 0; i < NODES; i++) begin
          sum_q[i] <= src[2*i] + src[2*i+1];
        end
        vld_q <= load ? 1'b0 : src_vld;
      end
    end
  end

  assign tree_out     = g_lvl[LEVELS-1].sum_q[0];
  assign tree_out_vld = g_lvl[LEVELS-1].vld_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start_in) begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (last_sum) begin
          state_d = BIAS;
        end
      end
      BIAS: begin
        state_d = OUT;
      end
      OUT: begin
        if (bus.out_ready_in) begin
          state_d = bus.start_in ? ACCUM : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from the current state
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid_c = (state_q == OUT);
    busy_c      = (state_q != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Bias, saturation and optional ReLU. The bias add is one bit wider than
  // the accumulator so it can never wrap before saturation.
  // ---------------------------------------------------------------------------
  always_comb begin
    biased_sum = $signed({acc_q[ACC_WIDTH-1], acc_q}) +
                 $signed({{(ACC_WIDTH+1-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q});
    if (biased_sum > SAT_MAX) begin
      sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (biased_sum < SAT_MIN) begin
      sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      sat_val = biased_sum[DATA_WIDTH-1:0];
    end
`ifdef ADDER_TREE_ACC_RELU_EN
    result_val = sat_val[DATA_WIDTH-1] ? '0 : sat_val;
`else
    result_val = sat_val;
`endif
  end

  // ---------------------------------------------------------------------------
  // Datapath: accumulator, sum counter, captured len/bias, result register
  // and the sticky error flag. out_data is only written in BIAS, so it stays
  // frozen for the whole OUT stall.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      bias_q     <= '0;
      out_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (group_mixed || group_late) begin
        err_q <= 1'b1;
      end

      if (load) begin
        acc_q  <= '0;
        cnt_q  <= '0;
        len_q  <= (bus.len_in == 8'd0) ? 8'd1 : bus.len_in;
        bias_q <= bus.bias_in;
      end else if ((state_q == ACCUM) && tree_out_vld) begin
        acc_q <= acc_q + tree_out;
        cnt_q <= cnt_q + 8'd1;
      end

      if (state_q == BIAS) begin
        out_data_q <= result_val;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_c;
  assign bus.busy_out  = busy_c;
  assign bus.err_out   = err_q;

endmodule
